dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: arbitration state and owner encoding.
// Imported by the arbiter and its testbench.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_LAST = 2'd0,
    DMA_LAST = 2'd1,
    DMA_LOCK = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data_mem port between the CPU MEM stage
// and a DMA/debug loader, with a bounded DMA locked burst.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_enable,
  output logic              mem_rd_enable,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [1:0]        owner,
  output logic              lock_active
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cpu_gnt;
  logic             w_dma_gnt;
  logic             w_locked;

  assign w_locked = (r_state == DMA_LOCK) & dma_req & dma_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DMA_LAST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_locked) begin
      if ((r_cnt < MAX_C) || !cpu_req) begin
        w_dma_gnt = 1'b1;
        if (r_cnt < MAX_C) w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        // burst budget spent: hand one beat to the waiting CPU
        w_cpu_gnt   = 1'b1;
        w_state_nxt = CPU_LAST;
        w_cnt_nxt   = '0;
      end
    end else begin
      if (cpu_req && dma_req) begin
        w_dma_gnt = (r_state == CPU_LAST);
        w_cpu_gnt = (r_state != CPU_LAST);
      end else begin
        w_cpu_gnt = cpu_req;
        w_dma_gnt = dma_req;
      end
      w_cnt_nxt = '0;
      unique case (1'b1)
        w_cpu_gnt: w_state_nxt = CPU_LAST;
        w_dma_gnt: begin
          w_state_nxt = dma_lock ? DMA_LOCK : DMA_LAST;
          w_cnt_nxt   = dma_lock ? CNT_W'(1) : '0;
        end
        default: begin
          if (r_state == DMA_LOCK) w_state_nxt = DMA_LAST;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr      = '0;
    mem_wr_data   = '0;
    mem_wr_enable = 1'b0;
    mem_rd_enable = 1'b0;
    cpu_rdata     = '0;
    dma_rdata     = '0;
    owner         = OWN_NONE;
    unique case (1'b1)
      w_cpu_gnt: begin
        owner         = OWN_CPU;
        mem_addr      = cpu_addr;
        mem_wr_data   = cpu_wdata;
        mem_wr_enable = cpu_we;
        mem_rd_enable = !cpu_we;
        if (!cpu_we) cpu_rdata = mem_rd_data;
      end
      w_dma_gnt: begin
        owner         = OWN_DMA;
        mem_addr      = dma_addr;
        mem_wr_data   = dma_wdata;
        mem_wr_enable = dma_we;
        mem_rd_enable = !dma_we;
        if (!dma_we) dma_rdata = mem_rd_data;
      end
      default: ;
    endcase
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign dma_gnt     = w_dma_gnt;
  assign cpu_stall   = cpu_req & !w_cpu_gnt;
  assign lock_active = (r_state == DMA_LOCK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-cycle expectations are queued
// as stimulus is driven and popped when the grant cycle is sampled.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt;
  logic [31:0] dma_addr;
  logic [63:0] dma_wdata, dma_rdata;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data, mem_rd_data;
  logic        mem_wr_enable, mem_rd_enable;
  logic [1:0]  owner;
  logic        lock_active;

  typedef struct {
    logic [1:0]  own;
    logic        stall;
    logic        chk_lock;
    logic        lock;
    logic [63:0] crd;
    logic [63:0] drd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [63:0] mem [256];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
    .mem_rd_data(mem_rd_data),
    .owner(owner), .lock_active(lock_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 64'hAB : 64'h0;
    end else if (mem_wr_enable) begin
      mem[mem_addr[7:0]] <= mem_wr_data;
    end
  end
  assign mem_rd_data = mem[mem_addr[7:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [63:0] cd,
                       input logic dr, input logic dw, input logic dl,
                       input logic [31:0] da, input logic [63:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl;
    dma_addr = da; dma_wdata = dd;
  endtask

  task automatic push(input logic [1:0] own, input logic stall,
                      input logic chk, input logic lk,
                      input logic [63:0] crd, input logic [63:0] drd);
    exp_t x;
    x.own = own; x.stall = stall; x.chk_lock = chk; x.lock = lk;
    x.crd = crd; x.drd = drd;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [232:0] got;
    do_reset();
    push(OWN_NONE, 0, 1, 0, 0, 0);
    #3;
    e = sb.pop_front();
    got = {owner, cpu_gnt, dma_gnt, cpu_stall, lock_active, mem_addr,
           mem_wr_data, mem_wr_enable, mem_rd_enable, cpu_rdata, dma_rdata};
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h required 0", got);
    end
    n_cmp++;
    if (owner !== e.own || lock_active !== e.lock) begin
      n_bad++;
      $display("FAIL reset_owner: got %b/%b required %b/%b",
               owner, lock_active, e.own, e.lock);
    end
    tick();
  endtask

  task automatic test_cpu_read();
    do_reset();
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    push(OWN_CPU, 0, 1, 0, 64'hAB, 0);
    #3;
    e = sb.pop_front();
    n_cmp++;
    if ({owner, cpu_gnt, dma_gnt, cpu_stall, cpu_rdata, dma_rdata} !==
        {e.own, e.own == OWN_CPU, e.own == OWN_DMA, e.stall, e.crd, e.drd}) begin
      n_bad++;
      $display("FAIL cpu_read: got own=%b stall=%b rd=%h required own=%b stall=%b rd=%h",
               owner, cpu_stall, cpu_rdata, e.own, e.stall, e.crd);
    end
    n_cmp++;
    if ({mem_addr, mem_rd_enable, mem_wr_enable} !== {32'h10, 2'b10}) begin
      n_bad++;
      $display("FAIL cpu_read_mem: got addr=%h rd=%b wr=%b required 10/1/0",
               mem_addr, mem_rd_enable, mem_wr_enable);
    end
    tick();
  endtask

  task automatic run_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      #3;
      e = sb.pop_front();
      n_cmp++;
      if ({owner, cpu_gnt, dma_gnt, cpu_stall, cpu_rdata, dma_rdata} !==
          {e.own, e.own == OWN_CPU, e.own == OWN_DMA, e.stall, e.crd, e.drd}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got own=%b g=%b%b st=%b crd=%h drd=%h required own=%b st=%b crd=%h drd=%h",
                 name, i, owner, cpu_gnt, dma_gnt, cpu_stall, cpu_rdata,
                 dma_rdata, e.own, e.stall, e.crd, e.drd);
      end
      if (e.chk_lock) begin
        n_cmp++;
        if (lock_active !== e.lock) begin
          n_bad++;
          $display("FAIL %s_lock[%0d]: got %b required %b",
                   name, i, lock_active, e.lock);
        end
      end
      #1;
    end
  endtask

  task automatic test_alternate();
    do_reset();
    drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h10, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(OWN_CPU, 0, 1, 0, 64'hAB, 0);
      else            push(OWN_DMA, 1, 1, 0, 0, 64'hAB);
    end
    run_cycles("alternate", 6);
    tick();
  endtask

  task automatic test_lock_burst();
    do_reset();
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    push(OWN_CPU, 0, 1, 0, 64'hAB, 0);
    run_cycles("lock_pre", 1);
    tick();
    drive(1, 0, 32'h10, 0, 1, 0, 1, 32'h10, 0);
    push(OWN_DMA, 1, 1, 0, 0, 64'hAB);
    push(OWN_DMA, 1, 1, 1, 0, 64'hAB);
    push(OWN_DMA, 1, 1, 1, 0, 64'hAB);
    push(OWN_DMA, 1, 1, 1, 0, 64'hAB);
    push(OWN_CPU, 0, 0, 0, 64'hAB, 0);
    push(OWN_DMA, 1, 1, 0, 0, 64'hAB);
    run_cycles("lock_burst", 6);
    tick();
  endtask

  task automatic test_lock_saturate();
    do_reset();
    drive(0, 0, 32'h10, 0, 1, 0, 1, 32'h10, 0);
    for (int i = 0; i < 10; i++)
      push(OWN_DMA, 0, 1, (i != 0), 0, 64'hAB);
    run_cycles("saturate", 10);
    tick();
    cpu_req = 1'b1;
    push(OWN_CPU, 0, 0, 0, 64'hAB, 0);
    push(OWN_DMA, 1, 1, 0, 0, 64'hAB);
    run_cycles("saturate_cpu", 2);
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 0, 32'h20, 64'h55);
    push(OWN_DMA, 0, 1, 0, 0, 0);
    #3;
    n_cmp++;
    if ({mem_wr_enable, mem_rd_enable, mem_addr, mem_wr_data} !==
        {2'b10, 32'h20, 64'h55}) begin
      n_bad++;
      $display("FAIL dma_write_mem: got we=%b re=%b a=%h d=%h required 1/0/20/55",
               mem_wr_enable, mem_rd_enable, mem_addr, mem_wr_data);
    end
    #1;
    run_cycles("dma_write", 1);
    tick();
    drive(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    push(OWN_CPU, 0, 1, 0, 64'h55, 0);
    run_cycles("cpu_readback", 1);
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(0, 0, 32'h10, 0, 1, 0, 1, 32'h10, 0);
    push(OWN_DMA, 0, 1, 0, 0, 64'hAB);
    run_cycles("mid_pre", 1);
    tick();
    drive(1, 0, 32'h10, 0, 1, 0, 1, 32'h10, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(OWN_CPU, 0, 1, 0, 64'hAB, 0);
    push(OWN_DMA, 1, 1, 0, 0, 64'hAB);
    run_cycles("mid_reset", 2);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_cpu_read();
    test_alternate();
    test_lock_burst();
    test_lock_saturate();
    test_write_read();
    test_reset_mid_burst();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
